// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the multi-cycle multiply/divide unit.
//   op_e    : operation select carried on muldiv_unit.op
//   state_e : controller states (IDLE -> RUN -> FIN -> IDLE)
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } state_e;

endpackage : muldiv_pkg

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: combinational conditional two's-complement negation.
//   N       : datapath width (2W for product/quotient, W for remainder)
//   i_val   : magnitude to fix
//   i_neg   : 1 = negate i_val
//   o_val_c : i_neg ? -i_val : i_val (combinational)
module muldiv_signfix #(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] i_val,
  input  logic         i_neg,
  output logic [N-1:0] o_val_c
);

  assign o_val_c = i_neg ? (~i_val + N'(1)) : i_val;

endmodule : muldiv_signfix

// File: rtl/muldiv_unit.sv
// muldiv_unit: sequential multiply/divide engine with architectural HI/LO.
//   Radix-2 shift-add multiply and restoring divide, one bit per cycle.
//   Build option: define MULDIV_DIV_EN to include the divider; without it
//   a start with op[1]=1 is ignored and no divide logic exists.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start, op     : launch request (sampled in IDLE) and operation select
//   a, b          : multiplicand/dividend, multiplier/divisor
//   we_hi, we_lo  : mthi/mtlo enables (honoured in IDLE only), data on wd
//   busy, done    : operation in progress / one-cycle result pulse
//   hi, lo        : HI and LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         we_hi,
  input  logic         we_lo,
  input  logic [W-1:0] wd,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int unsigned CW = $clog2(W);
  localparam int unsigned W2 = 2 * W;
`ifdef MULDIV_DIV_EN
  localparam logic DIV_EN = 1'b1;
`else
  localparam logic DIV_EN = 1'b0;
`endif

  state_e        r_state;
  state_e        w_next;
  logic          w_accept;
  logic          w_finish;

  logic          r_prep;
  logic [CW-1:0] r_cnt;
  logic          r_signed;
  logic          r_neg_res;
  logic [W-1:0]  r_opa;
  logic [W-1:0]  r_opb;
  logic [W-1:0]  r_opb_mag;
  logic [W2-1:0] r_acc;
  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;

  logic [W-1:0]  w_mag_a;
  logic [W-1:0]  w_mag_b;
  logic [W:0]    w_sum;
  logic [W2-1:0] w_acc_mul;
  logic [W2-1:0] w_acc_step;
  logic [W2-1:0] w_fix_in;
  logic [W2-1:0] w_fix_prod;
  logic [W-1:0]  w_res_hi;
  logic [W-1:0]  w_res_lo;
  logic          w_sa;
  logic          w_sb;

`ifdef MULDIV_DIV_EN
  logic          r_div;
  logic          r_neg_rem;
  logic          r_bzero;
  logic [W:0]    w_trial;
  logic [W:0]    w_diff;
  logic [W2-1:0] w_acc_div;
  logic [W-1:0]  w_fix_rem;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Operand signs only matter for the signed ops (op[0]=1).
  assign w_sa = op[0] & a[W-1];
  assign w_sb = op[0] & b[W-1];

  // Magnitudes are taken from the captured raw operands during the first RUN cycle.
  assign w_mag_a = (r_signed && r_opa[W-1]) ? (~r_opa + W'(1)) : r_opa;
  assign w_mag_b = (r_signed && r_opb[W-1]) ? (~r_opb + W'(1)) : r_opb;

  // Shift-add step: acc = {partial product, remaining multiplier bits}.
  assign w_sum     = {1'b0, r_acc[W2-1:W]} + (r_acc[0] ? {1'b0, r_opb_mag} : (W+1)'(0));
  assign w_acc_mul = {w_sum, r_acc[W-1:1]};

`ifdef MULDIV_DIV_EN
  // Restoring step: acc = {remainder, remaining dividend / quotient bits}.
  assign w_trial   = r_acc[W2-1:W-1];
  assign w_diff    = w_trial - {1'b0, r_opb_mag};
  assign w_acc_div = w_diff[W] ? {w_trial[W-1:0], r_acc[W-2:0], 1'b0}
                               : {w_diff[W-1:0],  r_acc[W-2:0], 1'b1};
  assign w_acc_step = r_div ? w_acc_div : w_acc_mul;
  assign w_fix_in   = r_div ? {W'(0), r_acc[W-1:0]} : r_acc;

  muldiv_signfix #(.N(W)) u_fix_rem (
    .i_val   (r_acc[W2-1:W]),
    .i_neg   (r_neg_rem),
    .o_val_c (w_fix_rem)
  );
`else
  assign w_acc_step = w_acc_mul;
  assign w_fix_in   = r_acc;
`endif

  // Product or quotient sign fix.
  muldiv_signfix #(.N(W2)) u_fix_prod (
    .i_val   (w_fix_in),
    .i_neg   (r_neg_res),
    .o_val_c (w_fix_prod)
  );

  // Result selection presented to HI/LO on the FIN -> IDLE edge.
  always_comb begin
    w_res_hi = w_fix_prod[W2-1:W];
    w_res_lo = w_fix_prod[W-1:0];
`ifdef MULDIV_DIV_EN
    if (r_div) begin
      if (r_bzero) begin
        w_res_hi = r_opa;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_fix_rem;
        w_res_lo = w_fix_prod[W-1:0];
      end
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and control strobes.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (DIV_EN || !op[1])) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        if (!r_prep && (r_cnt == CW'(0))) w_next = S_FIN;
      end
      S_FIN: begin
        w_finish = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath, handshake and HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prep    <= 1'b0;
      r_cnt     <= '0;
      r_signed  <= 1'b0;
      r_neg_res <= 1'b0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_opb_mag <= '0;
      r_acc     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
`ifdef MULDIV_DIV_EN
      r_div     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_bzero   <= 1'b0;
`endif
    end else begin
      // busy covers the W step cycles plus FIN, not the magnitude cycle.
      r_busy <= (r_state != S_IDLE) && (w_next != S_IDLE);
      r_done <= w_finish;

      if (w_accept) begin
        r_opa     <= a;
        r_opb     <= b;
        r_signed  <= op[0];
        r_neg_res <= w_sa ^ w_sb;
        r_cnt     <= CW'(W - 1);
        r_prep    <= 1'b1;
`ifdef MULDIV_DIV_EN
        r_div     <= op[1];
        r_neg_rem <= w_sa;
        r_bzero   <= (b == '0);
`endif
      end else if (r_state == S_RUN) begin
        if (r_prep) begin
          r_prep    <= 1'b0;
          r_acc     <= {W'(0), w_mag_a};
          r_opb_mag <= w_mag_b;
        end else begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt - CW'(1);
        end
      end

      if (w_finish) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (r_state == S_IDLE) begin
        if (we_hi) r_hi <= wd;
        if (we_lo) r_lo <= wd;
      end
    end
  end

endmodule : muldiv_unit

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (W=32).
//   Expected {hi,lo} pushed on each launched op, popped when done pulses.
//   Divide tests run when MULDIV_DIV_EN is defined; otherwise the ignored
//   divide request is exercised instead.
module tb_muldiv_unit;

  localparam int W        = 32;
  localparam int LAT      = W + 2;
  localparam int BUSY_CYC = W + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        we_hi, we_lo;
  logic [31:0] wd;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  muldiv_unit #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .we_hi (we_hi),
    .we_lo (we_lo),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    int     ix, iy, q, r;
    case (o)
      2'b00: return {32'h0, x} * {32'h0, y};
      2'b01: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
      end
      2'b10: return {x % y, x / y};
      default: begin
        ix = $signed(x);
        iy = $signed(y);
        q  = ix / iy;
        r  = ix % iy;
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("hi", {32'h0, hi}, {32'h0, e[63:32]});
        check("lo", {32'h0, lo}, {32'h0, e[31:0]});
      end
    end
  end

  // Launch one op (caller is just past a rising edge) and check its timing.
  task automatic do_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [63:0] exp, input int inject_at, input int poke_at,
                       input logic [31:0] poke_lo);
    int busy_n;
    int done_at;
    busy_n  = 0;
    done_at = 0;
    sb_q.push_back(exp);
    op = o; a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= LAT + 8; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      we_lo = 1'b0;
      if (i == poke_at + 1) check("busy_write_drop", {32'h0, lo}, {32'h0, poke_lo});
      if (busy) busy_n++;
      if (done) begin
        done_at = i;
        break;
      end
      if (i == inject_at) begin
        op = 2'b00; a = 32'h5; b = 32'h7; start = 1'b1;
      end
      if (i == poke_at) begin
        we_lo = 1'b1; wd = 32'hBEEF;
      end
    end
    check("done_latency", 64'(done_at), 64'(LAT));
    check("busy_cycles", 64'(busy_n), 64'(BUSY_CYC));
  endtask

  initial begin
    logic [31:0] ra, rb;
    int busy_n, done_n;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    we_hi = 1'b0; we_lo = 1'b0; wd = '0;
    #12;
    check("rst_busy", {63'h0, busy}, 64'd0);
    check("rst_done", {63'h0, done}, 64'd0);
    check("rst_hi", {32'h0, hi}, 64'd0);
    check("rst_lo", {32'h0, lo}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Multiply vectors (back-to-back launches).
    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, -1, -1, 0);
    do_op(2'b01, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, -1, -1, 0);
    do_op(2'b01, 32'h80000000, 32'h80000000, 64'h40000000_00000000, -1, -1, 0);
    // Second start during the op must be ignored.
    do_op(2'b00, 32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E_242D2080, 10, -1, 0);
    for (int k = 0; k < 3; k++) begin
      ra = $urandom; rb = $urandom;
      do_op(2'b00, ra, rb, model(2'b00, ra, rb), -1, -1, 0);
      ra = $urandom; rb = $urandom;
      do_op(2'b01, ra, rb, model(2'b01, ra, rb), -1, -1, 0);
    end

`ifdef MULDIV_DIV_EN
    do_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, -1, -1, 0);
    do_op(2'b10, 32'd100, 32'd0, 64'h00000064_FFFFFFFF, -1, -1, 0);
    do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, -1, -1, 0);
    do_op(2'b11, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, -1, -1, 0);
    do_op(2'b10, 32'd100, 32'd7, 64'h00000002_0000000E, -1, -1, 0);
    for (int k = 0; k < 3; k++) begin
      ra = $urandom; rb = $urandom | 32'h1;
      do_op(2'b10, ra, rb, model(2'b10, ra, rb), -1, -1, 0);
      ra = $urandom; rb = ($urandom | 32'h1) & 32'hFFFF_FFFD;
      do_op(2'b11, ra, rb, model(2'b11, ra, rb), -1, -1, 0);
    end
    op = 2'b11; a = 32'hFFFFFF9C; b = 32'd7;
`else
    op = 2'b00; a = 32'hFFFFFF9C; b = 32'd7;
`endif

    // Asynchronous reset in the middle of an operation.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", {63'h0, busy}, 64'd0);
    check("midrst_hi", {32'h0, hi}, 64'd0);
    check("midrst_lo", {32'h0, lo}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // mtlo / mthi in IDLE.
    we_lo = 1'b1; wd = 32'h1234;
    @(posedge clk); #1;
    we_lo = 1'b0;
    check("mtlo", {32'h0, lo}, 64'h1234);
    we_hi = 1'b1; wd = 32'hCAFE;
    @(posedge clk); #1;
    we_hi = 1'b0;
    check("mthi", {32'h0, hi}, 64'hCAFE);

`ifndef MULDIV_DIV_EN
    // divu request without the divider: nothing happens.
    busy_n = 0; done_n = 0;
    op = 2'b10; a = 32'd10; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < LAT + 6; i++) begin
      if (busy) busy_n++;
      if (done) done_n++;
      @(posedge clk); #1;
    end
    check("nodiv_busy", 64'(busy_n), 64'd0);
    check("nodiv_done", 64'(done_n), 64'd0);
    check("nodiv_hi", {32'h0, hi}, 64'hCAFE);
    check("nodiv_lo", {32'h0, lo}, 64'h1234);
`else
    busy_n = 0; done_n = 0;
`endif

    // mtlo while busy is dropped; result then overwrites HI/LO.
    do_op(2'b00, 32'd2, 32'd3, 64'h00000000_00000006, -1, 5, 32'h1234);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_muldiv_unit
